// File: rtl/sevseg_pkg.sv
// -----------------------------------------------------------------------------
// sevseg_pkg
// Shared constants and types for the four-digit 7-segment scanner.
//   NUM_DIGITS   : number of multiplexed digits on the board
//   digit_idx_t  : 2-bit digit index (0 = rightmost, 3 = leftmost)
//   SEG_*        : active-low cathode patterns, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
package sevseg_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [1:0] digit_idx_t;

   // Active-low: a 0 bit lights the segment. Bit order is {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
// Combinational BCD nibble to active-low 7-segment pattern.
// Codes 10..15 are not valid BCD and are shown as a dash so a corrupted
// upstream value is visible rather than silently mis-displayed.
// Ports:
//   nibble : input  [3:0] BCD digit
//   seg    : output [6:0] active-low cathodes, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
module bcd_to_seg
   import sevseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexed driver for a four-digit common-anode 7-segment display.
// One digit is selected per dwell of DIGIT_CYCLES clocks; the first
// BLANK_CYCLES clocks of every dwell keep all anodes off to suppress ghosting.
// The packed-BCD input is snapshotted once per frame (on the digit 3 -> 0
// wrap) so a frame never mixes old and new digits.
//
// Parameters:
//   DIGIT_CYCLES : clocks per digit dwell (>= 2)
//   BLANK_CYCLES : clocks of anode blanking at the start of each dwell
//                  (< DIGIT_CYCLES)
// Ports:
//   clk         : system clock
//   rst         : asynchronous reset, active-low
//   bcd_in      : packed BCD, [15:12] leftmost digit ... [3:0] rightmost
//   seg         : active-low segment cathodes, bit0 = a ... bit6 = g
//   an          : active-low digit anodes, bit n selects digit n
//   frame_start : one-cycle pulse in the cycle a new snapshot is taken
//
// Build option:
//   SEVSEG_ZERO_BLANK_EN : when defined, leading zeros on digits 3..1 are
//                          blanked (anode still driven, all segments off).
// -----------------------------------------------------------------------------
module seven_seg_scanner
   import sevseg_pkg::*;
#(
   parameter int unsigned DIGIT_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bcd_in,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_start
);

   localparam int unsigned        CNT_W    = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam digit_idx_t         IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt;
   digit_idx_t       idx;
   logic [15:0]      snap;

   logic             cnt_wrap;
   logic             frame_wrap;
   logic [3:0]       nibble;
   logic [6:0]       dec_seg;
   logic             in_blank;
   logic             digit_blank;
   logic [6:0]       seg_next;
   logic [3:0]       an_next;

`ifdef SEVSEG_ZERO_BLANK_EN
   // A digit is a leading zero when it and every digit to its left are zero.
   // The rightmost digit is always shown so "0000" still reads as 0.
   function automatic logic is_leading_zero(input logic [15:0] word,
                                            input digit_idx_t  d);
      logic result;
      result = 1'b0;
      case (d)
         2'd3:    result = (word[15:12] == 4'h0);
         2'd2:    result = (word[15:8]  == 8'h00);
         2'd1:    result = (word[15:4]  == 12'h000);
         default: result = 1'b0;
      endcase
      return result;
   endfunction

   assign digit_blank = is_leading_zero(snap, idx);
`else
   assign digit_blank = 1'b0;
`endif

   assign cnt_wrap   = (cnt == CNT_LAST);
   assign frame_wrap = cnt_wrap && (idx == IDX_LAST);

   // Single decoder shared by all digits; the nibble is selected by idx.
   assign nibble = snap[{idx, 2'b00} +: 4];

   bcd_to_seg u_bcd_to_seg (
      .nibble (nibble),
      .seg    (dec_seg)
   );

   assign in_blank = (32'(cnt) < BLANK_CYCLES);

   always_comb begin
      seg_next = dec_seg;
      an_next  = ~(4'b0001 << idx);
      if (in_blank) begin
         seg_next = SEG_OFF;
         an_next  = 4'hF;
      end else if (digit_blank) begin
         seg_next = SEG_OFF;
      end
   end

   // Scan state: dwell counter, digit index and per-frame snapshot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         idx  <= '0;
         snap <= 16'h0000;
      end else begin
         cnt <= cnt_wrap ? '0 : cnt + CNT_W'(1);
         if (cnt_wrap) begin
            idx <= idx + 2'd1;
         end
         if (frame_wrap) begin
            snap <= bcd_in;
         end
      end
   end

   // Registered pin drivers: one cycle behind the scan state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg         <= SEG_OFF;
         an          <= 4'hF;
         frame_start <= 1'b0;
      end else begin
         seg         <= seg_next;
         an          <= an_next;
         frame_start <= frame_wrap;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

   localparam int unsigned DC = 8;
   localparam int unsigned BC = 2;

   localparam logic [6:0] S0   = 7'h40;
   localparam logic [6:0] S1   = 7'h79;
   localparam logic [6:0] S2   = 7'h24;
   localparam logic [6:0] S3   = 7'h30;
   localparam logic [6:0] S4   = 7'h19;
   localparam logic [6:0] S5   = 7'h12;
   localparam logic [6:0] S6   = 7'h02;
   localparam logic [6:0] S7   = 7'h78;
   localparam logic [6:0] S8   = 7'h00;
   localparam logic [6:0] S9   = 7'h10;
   localparam logic [6:0] DASH = 7'h3F;
   localparam logic [6:0] OFF  = 7'h7F;

`ifdef SEVSEG_ZERO_BLANK_EN
   localparam bit ZB = 1'b1;
`else
   localparam bit ZB = 1'b0;
`endif
   // Expected pattern for a zero digit that is a leading zero.
   localparam logic [6:0] LZ = ZB ? OFF : S0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd_in = 16'h0000;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   int ec     = 0;   // posedges since the last reset release

   always #5 clk = ~clk;

   seven_seg_scanner #(
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bcd_in      (bcd_in),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 2 time units after posedge number 'target' (bounded by target).
   task automatic goto(input int target);
      while (ec < target) begin
         @(posedge clk);
         ec++;
      end
      #2;
   endtask

   // After edge k the outputs reflect state k-1: cnt=(k-1)%8, idx=((k-1)/8)%4.
   // Edge 32f+8n+5 samples digit n mid-dwell (cnt=4) of frame f.
   task automatic dig(input int f, input int n, input logic [6:0] exp_seg);
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << n);
      goto(32*f + 8*n + 5);
      chk($sformatf("an f%0d d%0d", f, n), {12'h0, an}, {12'h0, exp_an});
      chk($sformatf("seg f%0d d%0d", f, n), {9'h0, seg}, {9'h0, exp_seg});
   endtask

   initial begin
      // Reset held
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst an", {12'h0, an}, 16'h000F);
      chk("rst seg", {9'h0, seg}, {9'h0, OFF});
      chk("rst fs", {15'h0, frame_start}, 16'h0000);

      // Release, with live data already waiting
      bcd_in = 16'h1234;
      rst    = 1'b1;
      ec     = 0;

      // Frame 0 shows the reset snapshot, with anode blanking per dwell
      for (int n = 0; n < 4; n++) begin
         goto(8*n + 1);
         chk($sformatf("blank1 an d%0d", n), {12'h0, an}, 16'h000F);
         chk($sformatf("blank1 seg d%0d", n), {9'h0, seg}, {9'h0, OFF});
         goto(8*n + 2);
         chk($sformatf("blank2 an d%0d", n), {12'h0, an}, 16'h000F);
         dig(0, n, (n == 0) ? S0 : LZ);
      end

      // First snapshot pulse
      goto(31);
      chk("fs 31", {15'h0, frame_start}, 16'h0000);
      goto(32);
      chk("fs 32", {15'h0, frame_start}, 16'h0001);
      goto(33);
      chk("fs 33", {15'h0, frame_start}, 16'h0000);

      // Frame 1: 1234; input changes mid-frame at idx=1
      dig(1, 0, S4);
      dig(1, 1, S3);
      bcd_in = 16'h5678;
      dig(1, 2, S2);
      dig(1, 3, S1);
      goto(64);
      chk("fs 64", {15'h0, frame_start}, 16'h0001);

      // Frame 2: 5678
      dig(2, 0, S8);
      dig(2, 1, S7);
      bcd_in = 16'h0A09;
      dig(2, 2, S6);
      dig(2, 3, S5);

      // Frame 3: 0A09 -> dash on digit 2, digit 1 zero not leading
      dig(3, 0, S9);
      bcd_in = 16'h0000;
      dig(3, 1, S0);
      dig(3, 2, DASH);
      dig(3, 3, LZ);

      // Frame 4: 0000
      dig(4, 0, S0);
      dig(4, 1, LZ);
      dig(4, 2, LZ);
      dig(4, 3, LZ);
      bcd_in = 16'h1234;

      // Frame 5 holds 1234; reset at idx=2, cnt=5 (state 181)
      goto(181);
      chk("pre-rst an", {12'h0, an}, 16'h000B);
      chk("pre-rst seg", {9'h0, seg}, {9'h0, S2});
      rst = 1'b0;
      #1;
      chk("async an", {12'h0, an}, 16'h000F);
      chk("async seg", {9'h0, seg}, {9'h0, OFF});
      chk("async fs", {15'h0, frame_start}, 16'h0000);
      @(posedge clk);
      #2;
      bcd_in = 16'h5678;
      rst    = 1'b1;
      ec     = 0;

      // Snapshot cleared: frame 0 shows 0000 again, not 1234
      dig(0, 0, S0);
      dig(0, 3, LZ);
      goto(31);
      chk("post-rst fs 31", {15'h0, frame_start}, 16'h0000);
      goto(32);
      chk("post-rst fs 32", {15'h0, frame_start}, 16'h0001);
      dig(1, 0, S8);
      dig(1, 3, S5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
